md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//   Sequences the multiply/divide unit and owns HI/LO. Accepts md ops from E,
//   models fixed multi-cycle latency with a down-counter, commits HI/LO at
//   completion, and raises a D-stage stall while the unit is busy. Its read
//   mux drives E_HL_data, which the E->M register carries for mfhi/mflo.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
//   CNT_W        4   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-low reset (0 = reset)
//   E_md_op     in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   E_A         in   32  forwarded rs value
//   E_B         in   32  forwarded rt value
//   E_hl_sel    in   1   read select: 0 LO, 1 HI (mflo/mfhi in E)
//   D_md_use    in   1   D-stage instr is any md-class (mult..mflo)
//   E_HL_data   out  32  E_hl_sel ? HI : LO (combinational, pre-update value)
//   busy        out  1   unit occupied (cnt != 0)
//   D_md_stall  out  1   D_md_use & (busy | start)
//   HI          out  32  HI register
//   LO          out  32  LO register
// BEHAVIOUR
//   Reset (rst=0, async): HI=0, LO=0, cnt=0, pending op/result cleared;
//     so busy=0, D_md_stall=D_md_use&start, E_HL_data=0. Reset mid-op
//     abandons it; HI/LO stay 0 afterwards.
//   start = (E_md_op in 1..4) & ~busy. Ops 1..4 while busy are ignored.
//   States: IDLE (cnt==0), RUN (cnt!=0).
//   IDLE: start -> latch result (below), cnt<=MULT_CYCLES/DIV_CYCLES, RUN.
//     op 5: HI<=E_A at edge; op 6: LO<=E_A; stay IDLE. Op 7/0: no effect.
//   RUN: cnt<=cnt-1 each edge; on edge where cnt==1: HI/LO<=latched
//     result, cnt<=0 -> IDLE. Ops 5/6 while busy ignored (D stall prevents).
//   Latency: start in cycle t -> busy=1 in t+1..t+N, new HI/LO visible t+N+1;
//     a new start is accepted in t+N+1 at earliest.
//   Results (operands sampled at start only):
//     mult  {HI,LO}=$signed(A)*$signed(B), 64-bit
//     multu {HI,LO}=A*B unsigned, 64-bit
//     div   LO=$signed(A)/$signed(B), HI=$signed(A)%$signed(B) (trunc to 0,
//           HI sign = A sign); 0x80000000/-1 -> LO=0x80000000, HI=0
//     divu  LO=A/B, HI=A%B unsigned
//     B==0 for div/divu: full DIV_CYCLES busy, HI/LO unchanged at commit.
//   E_HL_data reads current HI/LO; never bypasses a same-cycle mthi/mtlo
//     or commit (decode ensures mf* is stalled behind busy).
//   D_md_stall is combinational; includes start so a following md instr
//     stalls in the same cycle the op enters E.
// TESTING
//   mult A=0xFFFFFFFE(-2),B=3 -> busy 5 cycles; then HI=0xFFFFFFFF,LO=0xFFFFFFFA
//   multu A=0xFFFFFFFF,B=2 -> HI=0x00000001,LO=0xFFFFFFFE after 5 busy cycles
//   div A=-7,B=2 -> 10 busy cycles; LO=0xFFFFFFFD,HI=0xFFFFFFFF; divu B=0
//     with HI/LO=0x11/0x22 -> unchanged after 10 cycles
//   mult start + D_md_use=1 -> D_md_stall=1 from start cycle through last busy
//     cycle, 0 in t+6; second mult held in E while busy is ignored
//   mthi 0xDEADBEEF idle, E_hl_sel=1 next cycle -> E_HL_data=0xDEADBEEF;
//     mtlo during busy -> LO unchanged
//   rst=0 asserted mid-div (cnt=4) -> immediately busy=0,HI=LO=0; after
//     release no commit occurs

Source files
------------

// File: rtl/md_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : md_scheduler
// Brief   : Multiply/divide sequencer owning HI/LO with a fixed-latency busy
//           window, D-stage stall generation and an E-stage HI/LO read mux.
// Revision: 1.0 - initial release
// ============================================================================
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_hl_sel,
  input  logic        D_md_use,
  output logic [31:0] E_HL_data,
  output logic        busy,
  output logic        D_md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;
  logic               r_res_wr;

  logic               w_busy;
  logic               w_start;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_b_nz;
  logic               w_div_ovf;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_div_s;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_div_u;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_res_wr;
  logic [CNT_W-1:0]   w_cycles;

  assign w_busy  = (r_cnt != '0);
  assign w_start = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && !w_busy;

  assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

  // Divisor is forced to 1 for B==0 (result discarded) and for the
  // 0x80000000/-1 overflow case, which then yields LO=0x80000000, HI=0.
  assign w_b_nz    = (E_B != 32'd0);
  assign w_div_ovf = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
  assign w_a_s     = $signed(E_A);
  assign w_div_s   = (!w_b_nz || w_div_ovf) ? 32'sd1 : $signed(E_B);
  assign w_q_s     = w_a_s / w_div_s;
  assign w_r_s     = w_a_s % w_div_s;
  assign w_div_u   = w_b_nz ? E_B : 32'd1;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b1;
    w_cycles = CNT_W'(DIV_CYCLES);
    case (E_md_op)
      OP_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_cycles = CNT_W'(MULT_CYCLES);
      end
      OP_DIV: begin
        w_res_lo = w_q_s;
        w_res_hi = w_r_s;
        w_res_wr = w_b_nz;
      end
      OP_DIVU: begin
        w_res_lo = E_A / w_div_u;
        w_res_hi = E_A % w_div_u;
        w_res_wr = w_b_nz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_res_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_res_hi <= w_res_hi;
            r_res_lo <= w_res_lo;
            r_res_wr <= w_res_wr;
            r_cnt    <= w_cycles;
            r_state  <= S_RUN;
          end else if (E_md_op == OP_MTHI) begin
            r_hi <= E_A;
          end else if (E_md_op == OP_MTLO) begin
            r_lo <= E_A;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_res_wr) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = w_busy;
  assign D_md_stall = D_md_use && (w_busy || w_start);
  assign E_HL_data  = E_hl_sel ? r_hi : r_lo;
  assign HI         = r_hi;
  assign LO         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_scheduler
// Brief   : Self-checking bench for md_scheduler against a cycle-indexed model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_md_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        duse;
  logic [31:0] E_HL_data;
  logic        busy;
  logic        D_md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .E_md_op   (op),
    .E_A       (a),
    .E_B       (b),
    .E_hl_sel  (sel),
    .D_md_use  (duse),
    .E_HL_data (E_HL_data),
    .busy      (busy),
    .D_md_stall(D_md_stall),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  // Model: an op started in cycle t occupies cycles t+1..done_at, results land at done_at's edge.
  int          cyc     = 0;
  int          done_at = -1;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;

  function automatic bit m_busy();
    return cyc <= done_at;
  endfunction

  function automatic bit m_start();
    return (op >= 3'd1) && (op <= 3'd4) && !m_busy();
  endfunction

  function automatic bit exp_stall();
    return duse && (m_busy() || m_start());
  endfunction

  task automatic m_reset();
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0;
    done_at = cyc - 1;
  endtask

  task automatic tick();
    bit bz, st;
    longint la, lb, q, r;
    logic [63:0] pr;
    bz = m_busy();
    st = m_start();
    if (bz && cyc == done_at && p_wr) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (st) begin
      p_wr = 1;
      la = longint'(int'(a));
      lb = longint'(int'(b));
      case (op)
        3'd1: begin pr = la * lb; {p_hi, p_lo} = pr; end
        3'd2: begin pr = {32'd0, a} * {32'd0, b}; {p_hi, p_lo} = pr; end
        3'd3: begin
          if (b == 0) p_wr = 0;
          else begin q = la / lb; r = la % lb; p_lo = q[31:0]; p_hi = r[31:0]; end
        end
        default: begin
          if (b == 0) p_wr = 0;
          else begin p_lo = a / b; p_hi = a % b; end
        end
      endcase
      done_at = cyc + ((op <= 3'd2) ? MC : DC);
    end else if (!bz && op == 3'd5) m_hi = a;
    else if (!bz && op == 3'd6) m_lo = a;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic go_idle();
    op = 0; duse = 0;
    for (int i = 0; i < 40 && m_busy(); i++) tick();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL go_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 0; op = 3'd1; a = 5; b = 6; sel = 0; duse = 1;
    m_reset();
    #3;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || E_HL_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b HI=%h LO=%h HL=%h required 0", busy, HI, LO, E_HL_data);
    end
    checks++;
    if (D_md_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall_start D_md_stall=%b required 1", D_md_stall);
    end
    op = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_mult();
    go_idle();
    op = 3'd1; a = 32'hFFFF_FFFE; b = 3; duse = 1; #1;
    checks++;
    if (D_md_stall !== 1'b1) begin
      failures++;
      $display("FAIL mult_start_stall D_md_stall=%b required 1", D_md_stall);
    end
    tick();
    for (int i = 1; i <= MC; i++) begin
      op = 3'd1; a = 32'h0001_2345; b = 7; #1;
      checks++;
      if (busy !== 1'b1 || D_md_stall !== 1'b1) begin
        failures++;
        $display("FAIL mult_busy_%0d busy=%b stall=%b required 1 1", i, busy, D_md_stall);
      end
      tick();
    end
    op = 0; #1;
    checks++;
    if (busy !== 1'b0 || D_md_stall !== 1'b0) begin
      failures++;
      $display("FAIL mult_done busy=%b stall=%b required 0 0", busy, D_md_stall);
    end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA || HI !== m_hi || LO !== m_lo) begin
      failures++;
      $display("FAIL mult_result HI=%h LO=%h required FFFFFFFF FFFFFFFA", HI, LO);
    end
  endtask

  task automatic test_multu();
    int n = 0;
    go_idle();
    op = 3'd2; a = 32'hFFFF_FFFF; b = 2; tick();
    op = 0;
    for (int i = 0; i < 30 && busy === 1'b1; i++) begin n++; tick(); end
    checks++;
    if (n != MC) begin
      failures++;
      $display("FAIL multu_latency busy_cycles=%0d required %0d", n, MC);
    end
    checks++;
    if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL multu_result HI=%h LO=%h required 00000001 FFFFFFFE", HI, LO);
    end
  endtask

  task automatic test_div();
    int n = 0;
    go_idle();
    op = 3'd3; a = 32'hFFFF_FFF9; b = 2; tick();
    op = 0;
    for (int i = 0; i < 30 && busy === 1'b1; i++) begin n++; tick(); end
    checks++;
    if (n != DC) begin
      failures++;
      $display("FAIL div_latency busy_cycles=%0d required %0d", n, DC);
    end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_result HI=%h LO=%h required FFFFFFFF FFFFFFFD", HI, LO);
    end
  endtask

  task automatic test_divzero();
    int n = 0;
    go_idle();
    op = 3'd5; a = 32'h11; tick();
    op = 3'd6; a = 32'h22; tick();
    op = 3'd4; a = 32'd123; b = 0; tick();
    op = 0;
    for (int i = 0; i < 30 && busy === 1'b1; i++) begin n++; tick(); end
    checks++;
    if (n != DC) begin
      failures++;
      $display("FAIL divzero_latency busy_cycles=%0d required %0d", n, DC);
    end
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      failures++;
      $display("FAIL divzero_hold HI=%h LO=%h required 00000011 00000022", HI, LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    go_idle();
    op = 3'd5; a = 32'hDEAD_BEEF; tick();
    op = 0; sel = 1; #1;
    checks++;
    if (E_HL_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mthi_read E_HL_data=%h required DEADBEEF", E_HL_data);
    end
    op = 3'd1; a = 3; b = 4; tick();
    op = 3'd6; a = 32'h0000_CAFE; tick();
    op = 0; sel = 0; #1;
    checks++;
    if (LO !== m_lo || E_HL_data !== m_lo) begin
      failures++;
      $display("FAIL mtlo_busy_ignored LO=%h HL=%h required %h", LO, E_HL_data, m_lo);
    end
    go_idle();
    checks++;
    if (HI !== 32'd0 || LO !== 32'd12) begin
      failures++;
      $display("FAIL mult_small HI=%h LO=%h required 00000000 0000000C", HI, LO);
    end
  endtask

  task automatic test_div_overflow();
    go_idle();
    op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; tick();
    go_idle();
    checks++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      failures++;
      $display("FAIL div_overflow HI=%h LO=%h required 00000000 80000000", HI, LO);
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    op = 3'd3; a = 32'd100; b = 32'd7; tick();
    op = 0;
    repeat (6) tick();
    #2 rst = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b HI=%h LO=%h required 0 0 0", busy, HI, LO);
    end
    m_reset();
    @(negedge clk);
    rst = 1;
    repeat (12) tick();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_commit busy=%b HI=%h LO=%h required 0 0 0", busy, HI, LO);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 11);
      op = (r <= 7) ? 3'(r) : 3'd0;
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 5);
        default: b = $urandom;
      endcase
      sel = 1'($urandom_range(0, 1));
      duse = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (busy !== m_busy() || D_md_stall !== exp_stall() || E_HL_data !== (sel ? m_hi : m_lo)) begin
        failures++;
        $display("FAIL rand_comb_%0d busy=%b stall=%b HL=%h required %b %b %h",
                 i, busy, D_md_stall, E_HL_data, m_busy(), exp_stall(), sel ? m_hi : m_lo);
      end
      tick();
      checks++;
      if (HI !== m_hi || LO !== m_lo) begin
        failures++;
        $display("FAIL rand_hilo_%0d HI=%h LO=%h required %h %h", i, HI, LO, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_mthi_mtlo();
    test_div_overflow();
    test_reset_mid();
    test_random();
    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
